imem_boot_loader: RTL and testbench

//  Upstream boot stage for Simple_RISC_Processor. Receives a program image as a byte

---
 rtl/imem_boot_loader.sv | 134 +++++++++++++
 tb/tb_imem_boot_loader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - byte-stream program loader that fills instruction memory and releases the core
module imem_boot_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_reset,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {HDR0, HDR1, DATA, CSUM, DONE, ERR} state_t;

    localparam logic [16:0] CAP = 17'(1) << ADDR_W;
    localparam int unsigned PAD = 17 - ADDR_W;

    state_t              state_q;
    logic [15:0]         len_q;
    logic [7:0]          csum_q;
    logic [1:0]          byte_cnt_q;
    logic [ADDR_W-1:0]   word_idx_q;
    logic [23:0]         word_buf_q;
    logic                in_ready_q;
    logic                imem_we_q;
    logic [31:0]         imem_addr_q;
    logic [31:0]         imem_wdata_q;
    logic                cpu_reset_q;
    logic                done_q;
    logic                err_q;

    logic                accept;
    logic [15:0]         len_d;
    logic [7:0]          csum_d;
    logic [31:0]         word_d;
    logic [31:0]         addr_d;
    logic                last_word;

    assign accept    = in_valid & in_ready_q;
    assign len_d     = {in_data, len_q[7:0]};
    assign csum_d    = csum_q ^ in_data;
    assign word_d    = {in_data, word_buf_q};
    assign addr_d    = BASE_ADDR + {{(30-ADDR_W){1'b0}}, word_idx_q, 2'b00};
    // Widened compare so a full-capacity image (N == 2**ADDR_W) is detected before k wraps.
    assign last_word = (({{PAD{1'b0}}, word_idx_q} + 17'd1) == {1'b0, len_q});

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q      <= HDR0;
            len_q        <= '0;
            csum_q       <= '0;
            byte_cnt_q   <= '0;
            word_idx_q   <= '0;
            word_buf_q   <= '0;
            in_ready_q   <= 1'b1;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= BASE_ADDR;
            imem_wdata_q <= '0;
            cpu_reset_q  <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            imem_we_q <= 1'b0;
            case (state_q)
                HDR0: if (accept) begin
                    len_q[7:0] <= in_data;
                    csum_q     <= csum_d;
                    state_q    <= HDR1;
                end
                HDR1: if (accept) begin
                    len_q  <= len_d;
                    csum_q <= csum_d;
                    if ({1'b0, len_d} > CAP) begin
                        state_q    <= ERR;
                        in_ready_q <= 1'b0;
                        err_q      <= 1'b1;
                    end else if (len_d == 16'd0) begin
                        state_q <= CSUM;
                    end else begin
                        state_q <= DATA;
                    end
                end
                DATA: if (accept) begin
                    csum_q     <= csum_d;
                    byte_cnt_q <= byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        imem_we_q    <= 1'b1;
                        imem_addr_q  <= addr_d;
                        imem_wdata_q <= word_d;
                        word_idx_q   <= word_idx_q + 1'b1;
                        if (last_word) begin
                            state_q <= CSUM;
                        end
                    end else begin
                        word_buf_q <= {in_data, word_buf_q[23:8]};
                    end
                end
                CSUM: if (accept) begin
                    in_ready_q <= 1'b0;
                    if (in_data == csum_q) begin
                        state_q     <= DONE;
                        done_q      <= 1'b1;
                        cpu_reset_q <= 1'b0;
                    end else begin
                        state_q <= ERR;
                        err_q   <= 1'b1;
                    end
                end
                DONE: ;
                ERR:  ;
                default: begin
                    state_q    <= ERR;
                    in_ready_q <= 1'b0;
                    err_q      <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_reset  = cpu_reset_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - self-checking bench: directed frame table, corner sequences, random frames vs model
module tb_imem_boot_loader;

    localparam int          ADDR_W = 2;
    localparam int          CAP    = 4;
    localparam logic [31:0] BASE   = 32'h0000_0100;

    logic        Clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        err;

    imem_boot_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .Clk        (Clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .err        (err)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] cap_addr[$], cap_data[$];
    logic [31:0] exp_addr[$], exp_data[$];
    bit          exp_done, exp_err;
    int          exp_cons;
    bit          done_seen = 1'b0;

    typedef struct {
        bit stall;
        bit exp_done;
        bit exp_err;
        int exp_nw;
    } vec_t;

    localparam int NV = 8;
    vec_t        vecs[NV];
    logic [7:0]  vframe[NV][$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic checkb(input string name, input logic act, input logic expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, expv);
        end
    endtask

    always @(negedge Clk) begin
        if (imem_we) begin
            cap_addr.push_back(imem_addr);
            cap_data.push_back(imem_wdata);
        end
        if (!reset && !cpu_reset && !done_seen) begin
            done_seen = 1'b1;
            check("writes_before_release", cap_addr.size(), exp_addr.size());
        end
    end

    // Reference: decode the frame from its byte layout, independent of any sequencing.
    task automatic model(input logic [7:0] f[$]);
        int n;
        logic [7:0] x;
        exp_addr.delete();
        exp_data.delete();
        n = int'({f[1], f[0]});
        if (n > CAP) begin
            exp_done = 1'b0;
            exp_err  = 1'b1;
            exp_cons = 2;
            return;
        end
        for (int k = 0; k < n; k++) begin
            exp_addr.push_back(BASE + 32'(4 * k));
            exp_data.push_back({f[2+4*k+3], f[2+4*k+2], f[2+4*k+1], f[2+4*k]});
        end
        x = 8'h00;
        for (int i = 0; i < 2 + 4 * n; i++) x ^= f[i];
        exp_cons = 3 + 4 * n;
        exp_done = (f[2+4*n] == x);
        exp_err  = !exp_done;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        @(negedge Clk);
        cap_addr.delete();
        cap_data.delete();
        done_seen = 1'b0;
        reset     = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] f[$], input bit stall, input int nbytes);
        int n;
        int nw;
        nw = (exp_cons >= 3) ? (exp_cons - 3) / 4 : 0;
        for (int i = 0; i < nbytes; i++) begin
            if (stall) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                @(negedge Clk);
            end
            in_valid = 1'b1;
            in_data  = f[i];
            n = 0;
            while (!in_ready && n < 20) begin
                @(negedge Clk);
                n++;
            end
            if (!in_ready) begin
                checkb("ready_timeout", in_ready, 1'b1);
                in_valid = 1'b0;
                return;
            end
            @(posedge Clk);
            #1;
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(negedge Clk);
            if (i >= 2 && i < 2 + 4 * nw && ((i - 2) % 4) == 3)
                checkb("we_latency", imem_we, 1'b1);
            if (i == 1 && exp_cons == 2)
                checkb("hdr_err", err, 1'b1);
            if (i == exp_cons - 1 && exp_cons > 2) begin
                checkb("done_next_cycle", done, exp_done);
                checkb("err_next_cycle", err, exp_err);
                checkb("cpu_reset_next_cycle", cpu_reset, !exp_done);
            end
        end
    endtask

    task automatic run_frame(input logic [7:0] f[$], input bit stall);
        int m;
        do_reset();
        model(f);
        send_frame(f, stall, exp_cons);
        repeat (3) @(negedge Clk);
        check("nwrites", cap_addr.size(), exp_addr.size());
        m = (cap_addr.size() < exp_addr.size()) ? cap_addr.size() : exp_addr.size();
        for (int k = 0; k < m; k++) begin
            check("waddr", cap_addr[k], exp_addr[k]);
            check("wdata", cap_data[k], exp_data[k]);
        end
        checkb("done", done, exp_done);
        checkb("err", err, exp_err);
        checkb("cpu_reset", cpu_reset, !exp_done);
        checkb("in_ready_end", in_ready, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        checkb({tag, "_in_ready"}, in_ready, 1'b1);
        checkb({tag, "_imem_we"}, imem_we, 1'b0);
        check({tag, "_imem_addr"}, imem_addr, BASE);
        check({tag, "_imem_wdata"}, imem_wdata, 32'h0);
        checkb({tag, "_cpu_reset"}, cpu_reset, 1'b1);
        checkb({tag, "_done"}, done, 1'b0);
        checkb({tag, "_err"}, err, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] f[$];

        vframe[0] = {8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h37, 8'h12, 8'h00, 8'h00, 8'h34};
        vframe[1] = {8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h37, 8'h12, 8'h00, 8'h00, 8'h00};
        vframe[2] = {8'h05, 8'h00};
        vframe[3] = {8'h00, 8'h00, 8'h00};
        vframe[4] = {8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h37, 8'h12, 8'h00, 8'h00, 8'h34};
        vframe[5] = {8'h04, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                     8'h09, 8'h0a, 8'h0b, 8'h0c, 8'h0d, 8'h0e, 8'h0f, 8'h10, 8'h14};
        vframe[6] = {8'h00, 8'h01};
        vframe[7] = {8'h01, 8'h00, 8'haa, 8'hbb, 8'hcc, 8'hdd, 8'h01};
        vecs[0] = '{1'b0, 1'b1, 1'b0, 2};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 2};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 0};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 2};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 4};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 0};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 1};

        repeat (2) @(negedge Clk);
        check_reset_values("rst");
        reset = 1'b0;
        @(negedge Clk);
        check_reset_values("idle");

        for (int v = 0; v < NV; v++) begin
            f = vframe[v];
            run_frame(f, vecs[v].stall);
            checkb("tbl_done", done, vecs[v].exp_done);
            checkb("tbl_err", err, vecs[v].exp_err);
            check("tbl_nw", cap_addr.size(), vecs[v].exp_nw);
        end

        // Known-good frame interrupted after five payload bytes, then replayed.
        f = vframe[0];
        do_reset();
        model(f);
        send_frame(f, 1'b0, 7);
        check("partial_writes", cap_addr.size(), 1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("async");
        @(negedge Clk);
        run_frame(f, 1'b0);

        for (int r = 0; r < 40; r++) begin
            int n;
            logic [7:0] x;
            f.delete();
            n = $urandom_range(0, 5);
            f.push_back(8'(n));
            f.push_back(8'h00);
            if (n <= CAP) begin
                for (int j = 0; j < 4 * n; j++) f.push_back(8'($urandom));
                x = 8'h00;
                for (int j = 0; j < f.size(); j++) x ^= f[j];
                if ($urandom_range(0, 3) == 0) x ^= 8'($urandom_range(1, 255));
                f.push_back(x);
            end else begin
                f.push_back(8'($urandom));
            end
            run_frame(f, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
